// File: rtl/wb_serial_pkg.sv
// Shared types and constants for the serial-to-Wishbone bridge:
// FSM state encoding, command/response bytes and frame field lengths.
package wb_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  localparam int ADDR_BYTES = 4;
  localparam int DATA_BYTES = 4;

endpackage

// File: rtl/wb_serial_master_if.sv
// Wishbone classic master/slave signal bundle used by wb_serial_master.
interface wb_serial_master_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_serial_resp.sv
// Serializes a 1- or 4-byte response (MSB first) onto the UART transmit
// strobe interface, honouring tx_busy except in the cycle after each strobe.
module wb_serial_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        len4_i,
  input  logic [31:0] word_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_o,
  output logic        busy_o
);

  logic [31:0] shift_q;
  logic [2:0]  left_q;
  logic [7:0]  tx_data_q;
  logic        tx_wr_q;
  logic        guard_q;
  logic        can_send;

  // The transmitter may not raise tx_busy until a cycle after our strobe,
  // so both the strobe cycle and the one after it are blind to tx_busy.
  assign can_send = (left_q != 3'd0) && !tx_wr_q && !guard_q && !tx_busy_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      left_q    <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      guard_q   <= 1'b0;
    end else begin
      guard_q <= tx_wr_q;
      tx_wr_q <= 1'b0;
      if (start_i) begin
        shift_q <= len4_i ? word_i : {word_i[7:0], 24'h0};
        left_q  <= len4_i ? 3'd4 : 3'd1;
      end else if (can_send) begin
        tx_data_q <= shift_q[31:24];
        shift_q   <= {shift_q[23:0], 8'h0};
        left_q    <= left_q - 3'd1;
        tx_wr_q   <= 1'b1;
      end
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_wr_o   = tx_wr_q;
  assign busy_o    = (left_q != 3'd0);

endmodule

// File: rtl/wb_serial_master.sv
// Byte-stream command decoder driving a 32-bit Wishbone master ('W'/'R').
// Optional bus timeout with 'E' response when WB_SERIAL_MASTER_TIMEOUT_EN is defined.
module wb_serial_master
  import wb_serial_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_avail,
  output logic                      rx_ack,
  output logic [7:0]                tx_data,
  output logic                      tx_wr,
  input  logic                      tx_busy,
  output logic                      busy,
  wb_serial_master_if.master        wb
);

  localparam logic [1:0] LAST_ADDR = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] LAST_DATA = 2'(DATA_BYTES - 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        is_write_q;
  logic [31:0] adr_sh_q;
  logic [31:0] dat_sh_q;
  logic        rx_ack_q;
  logic        rx_guard_q;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;

  logic        accept;
  logic        timeout_hit;
  logic        resp_start;
  logic        resp_len4;
  logic [31:0] resp_word;
  logic        resp_busy;

  assign accept = rx_avail && !rx_ack_q && !rx_guard_q &&
                  (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_DATA);

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
  logic [15:0] tmo_q;
  assign timeout_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_q != ST_BUS) tmo_q <= '0;
    else                            tmo_q <= tmo_q + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // An ack in the same cycle as the timeout takes the normal path.
  assign resp_start = (state_q == ST_BUS) && (wb.wb_ack_i || timeout_hit);
  assign resp_len4  = wb.wb_ack_i && !we_q;
  assign resp_word  = !wb.wb_ack_i ? {24'h0, RSP_ERR} :
                      we_q         ? {24'h0, RSP_OK}  : wb.wb_dat_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      adr_sh_q   <= '0;
      dat_sh_q   <= '0;
      rx_ack_q   <= 1'b0;
      rx_guard_q <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      sel_q      <= '0;
      dat_q      <= '0;
    end else begin
      rx_guard_q <= rx_ack_q;
      rx_ack_q   <= accept;
      case (state_q)
        ST_IDLE: begin
          if (accept && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
            state_q    <= ST_ADDR;
            is_write_q <= (rx_data == CMD_WRITE);
            cnt_q      <= '0;
          end
        end
        ST_ADDR: begin
          if (accept) begin
            adr_sh_q <= {adr_sh_q[23:0], rx_data};
            cnt_q    <= cnt_q + 2'd1;
            if (cnt_q == LAST_ADDR) begin
              cnt_q <= '0;
              if (is_write_q) begin
                state_q <= ST_DATA;
              end else begin
                state_q <= ST_BUS;
                adr_q   <= {adr_sh_q[23:0], rx_data};
                cyc_q   <= 1'b1;
                we_q    <= 1'b0;
                sel_q   <= 4'hF;
              end
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            dat_sh_q <= {dat_sh_q[23:0], rx_data};
            cnt_q    <= cnt_q + 2'd1;
            if (cnt_q == LAST_DATA) begin
              cnt_q   <= '0;
              state_q <= ST_BUS;
              adr_q   <= adr_sh_q;
              dat_q   <= {dat_sh_q[23:0], rx_data};
              cyc_q   <= 1'b1;
              we_q    <= 1'b1;
              sel_q   <= 4'hF;
            end
          end
        end
        ST_BUS: begin
          if (resp_start) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!resp_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  wb_serial_resp u_resp (
    .clk       (clk),
    .reset     (reset),
    .start_i   (resp_start),
    .len4_i    (resp_len4),
    .word_i    (resp_word),
    .tx_busy_i (tx_busy),
    .tx_data_o (tx_data),
    .tx_wr_o   (tx_wr),
    .busy_o    (resp_busy)
  );

  assign rx_ack      = rx_ack_q;
  assign busy        = (state_q != ST_IDLE);
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed scoreboard bench for wb_serial_master: UART-side byte driver,
// lagging transmitter model and a Wishbone slave with programmable wait states.
module tb_wb_serial_master;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic       busy;

  wb_serial_master_if wbif ();

  wb_serial_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_avail (rx_avail),
    .rx_ack   (rx_ack),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .wb       (wbif)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];

  int          slv_wait  = 0;
  logic [31:0] slv_rdata = '0;
  int          tx_hold   = 2;
  int          cyc_starts = 0;
  int          last_cyc_len = 0;
  int          rx_ack_cnt = 0;
  int          bytes_sent = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: acks after slv_wait stall cycles and checks each transfer.
  initial begin
    int   slv_cnt;
    int   cyc_len;
    logic prev_cyc;
    bus_t e;
    slv_cnt = 0;
    cyc_len = 0;
    prev_cyc = 1'b0;
    wbif.wb_ack_i = 1'b0;
    wbif.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wbif.wb_cyc_o) begin
        if (!prev_cyc) cyc_starts++;
        cyc_len++;
      end else begin
        if (prev_cyc) last_cyc_len = cyc_len;
        cyc_len = 0;
        check("we_low_when_idle", {31'h0, wbif.wb_we_o}, 32'h0);
      end
      prev_cyc = wbif.wb_cyc_o;
      if (wbif.wb_cyc_o && wbif.wb_stb_o && !wbif.wb_ack_i) begin
        if (slv_cnt == slv_wait) begin
          wbif.wb_ack_i = 1'b1;
          wbif.wb_dat_i = slv_rdata;
          check("bus_expected", 32'(exp_bus.size() != 0), 32'h1);
          if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check("bus_we", {31'h0, wbif.wb_we_o}, {31'h0, e.we});
            check("bus_adr", wbif.wb_adr_o, e.adr);
            check("bus_sel", {28'h0, wbif.wb_sel_o}, 32'hF);
            if (e.we) check("bus_dat", wbif.wb_dat_o, e.dat);
          end
        end else begin
          slv_cnt++;
        end
      end else begin
        wbif.wb_ack_i = 1'b0;
        slv_cnt = 0;
      end
    end
  end

  // Transmitter model (busy from 2 cycles after a strobe for tx_hold cycles)
  // plus tx scoreboard and rx_ack pulse counting.
  initial begin
    int start_in;
    int busy_left;
    int since_wr;
    logic [7:0] e;
    start_in = 0;
    busy_left = 0;
    since_wr = 100;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_ack) rx_ack_cnt++;
      since_wr++;
      if (tx_wr) begin
        check("tx_busy_at_launch", {31'h0, tx_busy}, 32'h0);
        check("tx_gap_ge3", 32'(since_wr >= 3), 32'h1);
        check("tx_expected", 32'(exp_tx.size() != 0), 32'h1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          check("tx_byte", {24'h0, tx_data}, {24'h0, e});
          $display("tx byte %02h (expected %02h)", tx_data, e);
        end
        since_wr = 0;
        start_in = 3;
      end
      if (start_in > 0) begin
        start_in--;
        if (start_in == 0) busy_left = tx_hold;
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 0;
    @(posedge clk); #1;
    rx_data = b;
    rx_avail = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_ack) begin
        got = 1;
        break;
      end
    end
    check("rx_ack_seen", {31'h0, got}, 32'h1);
    bytes_sent++;
    @(posedge clk); #1;
    rx_avail = 1'b0;
    @(negedge clk);
    check("rx_ack_one_cycle", {31'h0, rx_ack}, 32'h0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_read(input logic [31:0] adr, input logic [31:0] rd);
    bus_t e;
    e.we = 1'b0; e.adr = adr; e.dat = '0;
    exp_bus.push_back(e);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[i*8 +: 8]);
    slv_rdata = rd;
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_bus.size() == 0 && !busy && !tx_wr) begin
        ok = 1;
        break;
      end
    end
    check(tag, {31'h0, ok}, 32'h1);
  endtask

  initial begin
    bus_t e;
    int   starts0;
    bit   got;
    reset = 1'b1;
    rx_data = '0;
    rx_avail = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_rx_ack", {31'h0, rx_ack}, 32'h0);
    check("rst_tx_wr", {31'h0, tx_wr}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_cyc", {31'h0, wbif.wb_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wbif.wb_stb_o}, 32'h0);
    check("rst_adr", wbif.wb_adr_o, 32'h0);
    check("rst_sel", {28'h0, wbif.wb_sel_o}, 32'h0);
    check("rst_dat", wbif.wb_dat_o, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);

    // Write command
    e.we = 1'b1; e.adr = 32'h0000_1004; e.dat = 32'hDEAD_BEEF;
    exp_bus.push_back(e);
    exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h0000_1004);
    send_word(32'hDEAD_BEEF);
    wait_done("write_done");
    check("write_adr_held", wbif.wb_adr_o, 32'h0000_1004);
    check("write_dat_held", wbif.wb_dat_o, 32'hDEAD_BEEF);
    check("write_tx_data_held", {24'h0, tx_data}, 32'h4B);

    // Read with 3 wait states; a byte arriving mid-transaction stays pending
    slv_wait = 3;
    push_read(32'h0000_1004, 32'h1234_5678);
    send_byte(8'h52);
    send_word(32'h0000_1004);
    @(posedge clk); #1;
    rx_data = 8'hA5;
    rx_avail = 1'b1;
    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_ack) begin
        got = 1;
        check("pending_ack_after_resp", 32'(exp_tx.size()), 32'h0);
        check("pending_ack_busy", {31'h0, busy}, 32'h0);
        break;
      end
    end
    check("pending_byte_taken", {31'h0, got}, 32'h1);
    bytes_sent++;
    @(posedge clk); #1;
    rx_avail = 1'b0;
    wait_done("read_done");
    check("read_cyc_len", 32'(last_cyc_len), 32'd4);

    // Unknown byte is dropped, then a read works
    slv_wait = 0;
    starts0 = cyc_starts;
    send_byte(8'hA5);
    repeat (3) @(negedge clk);
    check("junk_busy", {31'h0, busy}, 32'h0);
    check("junk_no_cyc", 32'(cyc_starts - starts0), 32'h0);
    push_read(32'h0000_0040, 32'h0BAD_F00D);
    send_byte(8'h52);
    send_word(32'h0000_0040);
    wait_done("junk_then_read_done");

    // Reset mid-command discards the partial frame
    starts0 = cyc_starts;
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_cyc", {31'h0, wbif.wb_cyc_o}, 32'h0);
    push_read(32'h0000_2000, 32'hCAFE_F00D);
    send_byte(8'h52);
    send_word(32'h0000_2000);
    wait_done("midrst_read_done");
    check("midrst_one_bus_cycle", 32'(cyc_starts - starts0), 32'h1);

    // Slow transmitter during a read response
    tx_hold = 20;
    push_read(32'hFFFF_FFFC, 32'hA1B2_C3D4);
    send_byte(8'h52);
    send_word(32'hFFFF_FFFC);
    wait_done("slow_tx_done");
    tx_hold = 2;

`ifdef WB_SERIAL_MASTER_TIMEOUT_EN
    // Slave never acks: 8-cycle cycle then 'E'
    slv_wait = 1000;
    exp_tx.push_back(8'h45);
    send_byte(8'h52);
    send_word(32'h0000_3000);
    wait_done("timeout_read_done");
    check("timeout_cyc_len", 32'(last_cyc_len), 32'd8);
    exp_tx.push_back(8'h45);
    send_byte(8'h57);
    send_word(32'h0000_3004);
    send_word(32'h5555_AAAA);
    wait_done("timeout_write_done");
    check("timeout_write_cyc_len", 32'(last_cyc_len), 32'd8);
    // Ack on the last allowed cycle wins
    slv_wait = 7;
    push_read(32'h0000_3008, 32'h8765_4321);
    send_byte(8'h52);
    send_word(32'h0000_3008);
    wait_done("ack_at_limit_done");
    check("ack_at_limit_cyc_len", 32'(last_cyc_len), 32'd8);
`else
    // No timeout: a long stall still completes normally
    slv_wait = 20;
    push_read(32'h0000_3008, 32'h8765_4321);
    send_byte(8'h52);
    send_word(32'h0000_3008);
    wait_done("long_stall_done");
    check("long_stall_cyc_len", 32'(last_cyc_len), 32'd21);
`endif

    repeat (5) @(negedge clk);
    check("rx_ack_count", 32'(rx_ack_cnt), 32'(bytes_sent));
    check("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
